// File: rtl/delay_line_pkg.sv
// Shared constants, burst state encoding and timestamp helpers for the delay line.
package delay_line_pkg;

  // Fixed pipeline latency: sync (2) + FIFO write (1); the due test looks at the
  // previous counter value so that out rises exactly delay_cycles after sampling.
  localparam int unsigned LAT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } burst_state_e;

  // Due when the w-bit difference (due - now) is zero or negative.
  function automatic logic is_due(input logic [31:0] diff, input int unsigned w);
    logic [31:0] d;
    d = diff & ((32'd1 << w) - 32'd1);
    return (d == 32'd0) || d[w-1];
  endfunction

  // Keep the delay inside the window the due test can represent.
  function automatic logic [31:0] clamp_delay(input logic [31:0] d, input int unsigned w);
    logic [31:0] dmax;
    dmax = (32'd1 << (w - 1)) - 32'd1;
    if (d < 32'(LAT)) return 32'(LAT);
    if (d > dmax) return dmax;
    return d;
  endfunction

endpackage

// File: rtl/delay_line_ch.sv
// One channel: input synchroniser, edge detect with holdoff, timestamp FIFO, burst FSM.
module delay_line_ch
  import delay_line_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 600,
  parameter int unsigned CTR_W        = 18,
  parameter int unsigned EDGE_HOLDOFF = 202,
  parameter int unsigned HALF_PERIOD  = 5,
  parameter int unsigned BURST_PULSES = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_async,
  input  logic [CTR_W-1:0] ctr_ref,
  input  logic [CTR_W-1:0] due_ts,
  input  logic             clr_flags,
  output logic             out,
  output logic             fifo_full,
  output logic             overflow,
  output logic             late
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HOLD_W  = (EDGE_HOLDOFF > 0) ? $clog2(EDGE_HOLDOFF + 1) : 1;
  localparam int unsigned HALF_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned PULSE_W = (BURST_PULSES > 1) ? $clog2(BURST_PULSES) : 1;

  logic [2:0]         sync_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [CTR_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               empty;
  burst_state_e       state, state_nxt;
  logic [HALF_W-1:0]  half_cnt;
  logic [PULSE_W-1:0] pulse_cnt;

  logic               rise_c, accept_c, wr_c, drop_c, pop_c, due_c, late_set_c, out_d;
  logic [CTR_W-1:0]   head_c, diff_c;

  assign rise_c   = sync_q[1] & ~sync_q[2];
  assign accept_c = rise_c && (hold_q == '0);
  assign wr_c     = accept_c && !fifo_full;
  assign drop_c   = accept_c && fifo_full;
  assign head_c   = mem[rd_ptr];
  assign diff_c   = head_c - ctr_ref;
  assign due_c    = is_due(32'(diff_c), CTR_W);

  // Two-flop synchroniser plus one delayed copy for edge detection; holdoff lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hold_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], in_async};
      if (accept_c)          hold_q <= HOLD_W'(EDGE_HOLDOFF);
      else if (hold_q != '0) hold_q <= hold_q - HOLD_W'(1);
    end
  end

  // Timestamp storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_c) mem[wr_ptr] <= due_ts;
  end

  // Occupancy after this cycle's write/pop.
  always_comb begin
    count_nxt = count;
    if (wr_c && !pop_c)      count_nxt = count + CNT_W'(1);
    else if (!wr_c && pop_c) count_nxt = count - CNT_W'(1);
  end

  // FIFO pointers and exact registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      empty     <= 1'b1;
      fifo_full <= 1'b0;
    end else begin
      if (wr_c)  wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop_c) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      fifo_full <= (count_nxt == CNT_W'(FIFO_DEPTH));
    end
  end

  // Burst state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state; events are popped only from IDLE.
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && due_c) begin
          pop_c     = 1'b1;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (half_cnt == HALF_W'(HALF_PERIOD - 1)) state_nxt = LOW;
      end
      LOW: begin
        if (half_cnt == HALF_W'(HALF_PERIOD - 1))
          state_nxt = (pulse_cnt == PULSE_W'(BURST_PULSES - 1)) ? IDLE : HIGH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: drive level follows the state being entered; late if popped off-time.
  always_comb begin
    out_d      = (state_nxt == HIGH);
    late_set_c = pop_c && (diff_c != '0);
  end

  // Registered outputs, phase counters and sticky flags (set beats clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= 1'b0;
      half_cnt  <= '0;
      pulse_cnt <= '0;
      overflow  <= 1'b0;
      late      <= 1'b0;
    end else begin
      out <= out_d;
      if (state == IDLE || state_nxt != state) half_cnt <= '0;
      else                                     half_cnt <= half_cnt + HALF_W'(1);
      if (state == IDLE)                           pulse_cnt <= '0;
      else if (state == LOW && state_nxt == HIGH)  pulse_cnt <= pulse_cnt + PULSE_W'(1);
      if (drop_c)         overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (late_set_c)     late <= 1'b1;
      else if (clr_flags) late <= 1'b0;
    end
  end

endmodule

// File: rtl/delay_line_mc.sv
// Multi-channel delay line: shared timestamp counter and delay clamp feeding NUM_CH channels.
module delay_line_mc
  import delay_line_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned FIFO_DEPTH   = 600,
  parameter int unsigned CTR_W        = 18,
  parameter int unsigned EDGE_HOLDOFF = 202,
  parameter int unsigned HALF_PERIOD  = 5,
  parameter int unsigned BURST_PULSES = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] in,
  input  logic [CTR_W-1:0]  delay_cycles,
  input  logic              clr_flags,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] fifo_full,
  output logic [NUM_CH-1:0] overflow,
  output logic [NUM_CH-1:0] late
);

  logic [CTR_W-1:0] ctr, ctr_q, dly_c, due_c;

  assign dly_c = CTR_W'(clamp_delay(32'(delay_cycles), CTR_W));
  assign due_c = ctr + dly_c - CTR_W'(LAT);

  // Free-running timestamp counter and its one-cycle-old copy used by the due test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctr   <= '0;
      ctr_q <= '0;
    end else begin
      ctr   <= ctr + CTR_W'(1);
      ctr_q <= ctr;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_line_ch #(
      .FIFO_DEPTH   (FIFO_DEPTH),
      .CTR_W        (CTR_W),
      .EDGE_HOLDOFF (EDGE_HOLDOFF),
      .HALF_PERIOD  (HALF_PERIOD),
      .BURST_PULSES (BURST_PULSES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .in_async  (in[i]),
      .ctr_ref   (ctr_q),
      .due_ts    (due_c),
      .clr_flags (clr_flags),
      .out       (out[i]),
      .fifo_full (fifo_full[i]),
      .overflow  (overflow[i]),
      .late      (late[i])
    );
  end

endmodule

// File: tb/tb_delay_line_mc.sv
// Directed bench: default instance (a), small-FIFO/narrow-counter instance (b), slow-modulation instance (c).
module tb_delay_line_mc;

  logic        clk, rst, clr;
  logic [3:0]  in_a, in_b, in_c;
  logic [17:0] dly_a, dly_c;
  logic [13:0] dly_b;
  logic [3:0]  out_a, full_a, ovf_a, late_a;
  logic [3:0]  out_b, full_b, ovf_b, late_b;
  logic [3:0]  out_c, full_c, ovf_c, late_c;
  int          cyc;
  int          n_chk, n_fail;

  delay_line_mc u_a (
    .clk(clk), .rst(rst), .in(in_a), .delay_cycles(dly_a), .clr_flags(clr),
    .out(out_a), .fifo_full(full_a), .overflow(ovf_a), .late(late_a)
  );

  delay_line_mc #(.FIFO_DEPTH(4), .CTR_W(14)) u_b (
    .clk(clk), .rst(rst), .in(in_b), .delay_cycles(dly_b), .clr_flags(clr),
    .out(out_b), .fifo_full(full_b), .overflow(ovf_b), .late(late_b)
  );

  delay_line_mc #(.HALF_PERIOD(20)) u_c (
    .clk(clk), .rst(rst), .in(in_c), .delay_cycles(dly_c), .clr_flags(clr),
    .out(out_c), .fifo_full(full_c), .overflow(ovf_c), .late(late_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles since reset release; equals the DUT counter modulo its width.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Expected burst level k clocks after the first sampling edge, for a burst starting at s.
  function automatic logic burst_bit(input int k, input int s, input int h);
    int rel;
    rel = k - s;
    return (rel >= 0) && (rel < 2 * h * 13) && ((rel % (2 * h)) < h);
  endfunction

  // Input level sampled at edge k for a 20-cycle pulse starting at e.
  function automatic logic pulse(input int k, input int e);
    return (k >= e) && (k < e + 20);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({out_a, full_a, ovf_a, late_a} !== 16'h0) begin
      n_fail++; $display("FAIL reset_a got=%h exp=0000", {out_a, full_a, ovf_a, late_a});
    end
    n_chk++;
    if ({out_b, full_b, ovf_b, late_b} !== 16'h0) begin
      n_fail++; $display("FAIL reset_b got=%h exp=0000", {out_b, full_b, ovf_b, late_b});
    end
    n_chk++;
    if ({out_c, full_c, ovf_c, late_c} !== 16'h0) begin
      n_fail++; $display("FAIL reset_c got=%h exp=0000", {out_c, full_c, ovf_c, late_c});
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({out_a, out_b, out_c, full_a, full_b, full_c} !== 24'h0) begin
      n_fail++; $display("FAIL reset_release got=%h exp=000000", {out_a, out_b, out_c, full_a, full_b, full_c});
    end
  endtask

  task automatic test_single_edge();
    logic [3:0] exp;
    dly_a = 18'd1000;
    for (int k = 0; k < 1200; k++) begin
      in_a[0] = pulse(k, 0);
      @(posedge clk); #1;
      exp = {3'b000, burst_bit(k, 1000, 5)};
      n_chk++;
      if (out_a !== exp) begin
        n_fail++; $display("FAIL single_edge k=%0d out=%b exp=%b", k, out_a, exp);
      end
    end
  endtask

  task automatic test_min_delay();
    logic [3:0] exp;
    dly_a = 18'd0;
    for (int k = 0; k < 160; k++) begin
      in_a[1] = pulse(k, 0);
      @(posedge clk); #1;
      exp = {2'b00, burst_bit(k, 3, 5), 1'b0};
      n_chk++;
      if (out_a !== exp) begin
        n_fail++; $display("FAIL min_delay k=%0d out=%b exp=%b", k, out_a, exp);
      end
    end
  endtask

  task automatic test_holdoff();
    logic [3:0] exp;
    dly_a = 18'd1000;
    for (int k = 0; k < 1450; k++) begin
      in_a[2] = pulse(k, 0) | pulse(k, 100) | pulse(k, 300);
      @(posedge clk); #1;
      exp = {1'b0, burst_bit(k, 1000, 5) | burst_bit(k, 1300, 5), 2'b00};
      n_chk++;
      if (out_a !== exp) begin
        n_fail++; $display("FAIL holdoff k=%0d out=%b exp=%b", k, out_a, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    dly_a = 18'd1000;
    for (int k = 0; k < 1360; k++) begin
      in_a[3] = pulse(k, 0) | pulse(k, 210);
      @(posedge clk); #1;
      exp = {burst_bit(k, 1000, 5) | burst_bit(k, 1210, 5), 3'b000};
      n_chk++;
      if (out_a !== exp) begin
        n_fail++; $display("FAIL back_to_back k=%0d out=%b exp=%b", k, out_a, exp);
      end
    end
    n_chk++;
    if ({late_a, ovf_a, full_a} !== 12'h0) begin
      n_fail++; $display("FAIL back_to_back_flags got=%h exp=000", {late_a, ovf_a, full_a});
    end
  endtask

  task automatic test_fifo_overflow();
    logic [3:0] exp_o, exp_f, exp_v;
    dly_b = 14'd5000;
    for (int k = 0; k < 6040; k++) begin
      in_b[1] = pulse(k, 0) | pulse(k, 300) | pulse(k, 600) | pulse(k, 900) | pulse(k, 1200) | pulse(k, 1500);
      @(posedge clk); #1;
      exp_o = {2'b00, burst_bit(k, 5000, 5) | burst_bit(k, 5300, 5) | burst_bit(k, 5600, 5) | burst_bit(k, 5900, 5), 1'b0};
      exp_f = {2'b00, (k >= 902) && (k < 5000), 1'b0};
      exp_v = {2'b00, (k >= 1202), 1'b0};
      n_chk++;
      if (out_b !== exp_o) begin
        n_fail++; $display("FAIL fifo_out k=%0d out=%b exp=%b", k, out_b, exp_o);
      end
      n_chk++;
      if (full_b !== exp_f) begin
        n_fail++; $display("FAIL fifo_full k=%0d full=%b exp=%b", k, full_b, exp_f);
      end
      n_chk++;
      if (ovf_b !== exp_v) begin
        n_fail++; $display("FAIL fifo_overflow k=%0d ovf=%b exp=%b", k, ovf_b, exp_v);
      end
    end
  endtask

  task automatic test_late_clear();
    logic [3:0] exp_o, exp_l;
    dly_c = 18'd1000;
    for (int k = 0; k < 2051; k++) begin
      in_c[0] = pulse(k, 0) | pulse(k, 210);
      @(posedge clk); #1;
      exp_o = {3'b000, burst_bit(k, 1000, 20) | burst_bit(k, 1521, 20)};
      exp_l = {3'b000, (k >= 1521)};
      n_chk++;
      if (out_c !== exp_o) begin
        n_fail++; $display("FAIL late_out k=%0d out=%b exp=%b", k, out_c, exp_o);
      end
      n_chk++;
      if (late_c !== exp_l) begin
        n_fail++; $display("FAIL late_flag k=%0d late=%b exp=%b", k, late_c, exp_l);
      end
    end
    n_chk++;
    if (ovf_b !== 4'b0010) begin
      n_fail++; $display("FAIL ovf_sticky got=%b exp=0010", ovf_b);
    end
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    n_chk++;
    if (late_c !== 4'b0000) begin
      n_fail++; $display("FAIL clr_late got=%b exp=0000", late_c);
    end
    n_chk++;
    if (ovf_b !== 4'b0000) begin
      n_fail++; $display("FAIL clr_overflow got=%b exp=0000", ovf_b);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp;
    int target, guard;
    dly_b = 14'd500;
    target = cyc - (cyc % 16384) + 16384 - 250;
    if (target - cyc < 5) target += 16384;
    guard = 0;
    while (cyc != target - 1 && guard < 40000) begin
      @(posedge clk); #1;
      guard++;
    end
    n_chk++;
    if (cyc != target - 1) begin
      n_fail++; $display("FAIL wrap_wait cyc=%0d exp=%0d", cyc, target - 1);
    end
    for (int k = 0; k < 700; k++) begin
      in_b[3] = pulse(k, 0);
      @(posedge clk); #1;
      exp = {burst_bit(k, 500, 5), 3'b000};
      n_chk++;
      if (out_b !== exp) begin
        n_fail++; $display("FAIL wrap k=%0d out=%b exp=%b", k, out_b, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp;
    dly_a = 18'd1000;
    for (int k = 0; k <= 1050; k++) begin
      in_a[0] = pulse(k, 0) | pulse(k, 250) | pulse(k, 500) | pulse(k, 750);
      @(posedge clk); #1;
      exp = {3'b000, burst_bit(k, 1000, 5)};
      n_chk++;
      if (out_a !== exp) begin
        n_fail++; $display("FAIL pre_reset k=%0d out=%b exp=%b", k, out_a, exp);
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({out_a, full_a, ovf_a, late_a} !== 16'h0) begin
      n_fail++; $display("FAIL async_reset got=%h exp=0000", {out_a, full_a, ovf_a, late_a});
    end
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if ({out_a, full_a, ovf_a, late_a} !== 16'h0) begin
        n_fail++; $display("FAIL post_reset k=%0d got=%h exp=0000", k, {out_a, full_a, ovf_a, late_a});
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clr    = 1'b0;
    in_a   = '0;
    in_b   = '0;
    in_c   = '0;
    dly_a  = 18'd1000;
    dly_b  = 14'd5000;
    dly_c  = 18'd1000;
    test_reset();
    test_single_edge();
    test_min_delay();
    test_holdoff();
    test_back_to_back();
    test_fifo_overflow();
    test_late_clear();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
